// File: rtl/gcd_share_arbiter_if.sv
// Bundle of requester, core and response channels around the shared GCD core.
// slave: arbiter side. master: environment side (requesters, core, consumer).
interface gcd_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int W       = 16
);
    // Requester channel (one valid/ready pair per requester, flattened operands)
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [NUM_REQ*W-1:0] req_c;

    // Core channel
    logic                 core_start;
    logic [W-1:0]         core_a;
    logic [W-1:0]         core_b;
    logic [W-1:0]         core_c;
    logic                 core_reset;
    logic [W-1:0]         core_d;
    logic                 core_valid;

    // Shared response channel
    logic                 resp_valid;
    logic                 resp_ready;
    logic [W-1:0]         resp_d;
    logic [ID_W-1:0]      resp_id;
    logic                 resp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_c,
        input  core_d, core_valid,
        input  resp_ready,
        output req_ready,
        output core_start, core_a, core_b, core_c, core_reset,
        output resp_valid, resp_d, resp_id, resp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_c,
        output core_d, core_valid,
        output resp_ready,
        input  req_ready,
        input  core_start, core_a, core_b, core_c, core_reset,
        input  resp_valid, resp_d, resp_id, resp_err
    );
endinterface

// File: rtl/gcd_share_arbiter.sv
// Round-robin scheduler sharing one gcd_top core among NUM_REQ requesters.
// One request in flight at a time; stale core_valid is ignored until the core
// drops it, a wait-cycle budget aborts a hung core, and results return on one
// shared response channel tagged with the requester index.
module gcd_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int W       = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,   // asynchronous, active-low
    gcd_share_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_RESP,
        S_ABORT
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [ID_W-1:0]    r_id;
    logic [W-1:0]       r_core_a;
    logic [W-1:0]       r_core_b;
    logic [W-1:0]       r_core_c;
    logic [W-1:0]       r_resp_d;
    logic               r_resp_err;
    logic               r_core_rst_init;

    logic               w_grant_found;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_scan;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [W-1:0]       w_sel_a;
    logic [W-1:0]       w_sel_b;
    logic [W-1:0]       w_sel_c;
    logic               w_accept;
    logic               w_zero_ops;
    logic               w_timeout;

    // Increment a requester index with wrap at NUM_REQ (handles non-power-of-two counts).
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    // Round-robin search: first valid requester at or after the pointer, with wrap.
    // NOTE: every variable written in a combinational block gets a default at the
    // top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan        = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_found && bus.req_valid[w_scan]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan;
            end
            w_scan = wrap_inc(w_scan);
        end
    end

    // One-hot accept strobe and operand mux for the granted requester.
    always_comb begin
        w_req_ready = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_c     = '0;
        if (r_state == S_IDLE && w_grant_found) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == PTR_W'(i)) begin
                w_sel_a = bus.req_a[i*W +: W];
                w_sel_b = bus.req_b[i*W +: W];
                w_sel_c = bus.req_c[i*W +: W];
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_grant_found;
    assign w_zero_ops = (w_sel_a == '0) && (w_sel_b == '0) && (w_sel_c == '0);
    // Last permitted wait cycle; the abort wins over a same-cycle core_valid.
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next_state = w_zero_ops ? S_RESP : S_START;
            S_START:     w_next_state = S_WAIT_LOW;
            S_WAIT_LOW:  if (w_timeout)            w_next_state = S_ABORT;
                         else if (!bus.core_valid) w_next_state = S_WAIT_HIGH;
            S_WAIT_HIGH: if (w_timeout)            w_next_state = S_ABORT;
                         else if (bus.core_valid)  w_next_state = S_RESP;
            S_ABORT:     w_next_state = S_RESP;
            S_RESP:      if (bus.resp_ready) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand/ID capture on accept, wait counter, response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_id       <= '0;
            r_core_a   <= '0;
            r_core_b   <= '0;
            r_core_c   <= '0;
            r_resp_d   <= '0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_core_a <= w_sel_a;
                r_core_b <= w_sel_b;
                r_core_c <= w_sel_c;
                r_id     <= ID_W'(w_grant_idx);
                r_ptr    <= wrap_inc(w_grant_idx);
                if (w_zero_ops) begin
                    r_resp_d   <= '0;
                    r_resp_err <= 1'b0;
                end
            end
            case (r_state)
                S_START: r_cnt <= '0;
                S_WAIT_LOW: r_cnt <= r_cnt + 1'b1;
                S_WAIT_HIGH: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_timeout && bus.core_valid) begin
                        r_resp_d   <= bus.core_d;
                        r_resp_err <= 1'b0;
                    end
                end
                S_ABORT: begin
                    r_resp_d   <= '0;
                    r_resp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Core held in reset during system reset and released on the first edge after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_core_rst_init <= 1'b1;
        else        r_core_rst_init <= 1'b0;
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.core_start = (r_state == S_START);
    assign bus.core_a     = r_core_a;
    assign bus.core_b     = r_core_b;
    assign bus.core_c     = r_core_c;
    assign bus.core_reset = r_core_rst_init | (r_state == S_ABORT);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_d     = r_resp_d;
    assign bus.resp_id    = r_id;
    assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_gcd_share_arbiter.sv
// Directed bench for gcd_share_arbiter: a behavioural GCD core model, a
// scoreboard queue of expected responses, and immediate assertions.
module tb_gcd_share_arbiter;

    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int W   = 16;
    localparam int TO  = 16;

    typedef struct {
        logic [W-1:0]   d;
        logic [IDW-1:0] id;
        logic           err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    gcd_share_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW), .W(W)) bus ();

    gcd_share_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .W(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int   cyc = 0;
    int   n_start, n_ready_cyc, n_core_rst;
    int   acc_cyc, start_cyc, resp_rise_cyc, core_rst_cyc;
    logic           s_resp_valid, s_resp_hs, s_resp_err;
    logic [W-1:0]   s_resp_d;
    logic [IDW-1:0] s_resp_id;
    logic           prev_rv = 1'b0;

    // Core model knobs and state
    int           core_delay   = 5;
    int           stale_cycles = 0;
    bit           hang         = 1'b0;
    int           m_cnt, m_stale, m_rise_cyc;
    bit           m_busy = 1'b0;
    logic [W-1:0] m_res;

    function automatic logic [W-1:0] gcd2(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] a = x;
        logic [W-1:0] b = y;
        logic [W-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [W-1:0] gcd3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        return gcd2(gcd2(a, b), c);
    endfunction

    // Behavioural core: valid is sticky after completion; on start it either drops
    // at once or, for stale_cycles>0, lingers that many cycles with the old result.
    always @(negedge clk) begin
        if (bus.core_reset) begin
            bus.core_valid = 1'b0;
            bus.core_d     = '0;
            m_busy         = 1'b0;
        end else if (bus.core_start) begin
            m_busy  = 1'b1;
            m_cnt   = 0;
            m_stale = stale_cycles;
            m_res   = gcd3(bus.core_a, bus.core_b, bus.core_c);
            if (m_stale == 0) bus.core_valid = 1'b0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_stale > 0) begin
                m_stale--;
                if (m_stale == 0) bus.core_valid = 1'b0;
            end
            if (!hang && m_cnt >= core_delay) begin
                bus.core_valid = 1'b1;
                bus.core_d     = m_res;
                m_busy         = 1'b0;
                m_rise_cyc     = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample mid-cycle, then drive just after the rising edge.
    task automatic step();
        logic [NR-1:0] hs;
        @(negedge clk);
        hs = reset ? (bus.req_valid & bus.req_ready) : '0;
        if (reset && bus.req_ready != '0) n_ready_cyc++;
        if (hs != '0) acc_cyc = cyc;
        if (bus.core_start) begin n_start++; start_cyc = cyc; end
        if (bus.core_reset) begin n_core_rst++; core_rst_cyc = cyc; end
        s_resp_valid = bus.resp_valid;
        s_resp_hs    = bus.resp_valid & bus.resp_ready;
        s_resp_d     = bus.resp_d;
        s_resp_id    = bus.resp_id;
        s_resp_err   = bus.resp_err;
        if (bus.resp_valid && !prev_rv) resp_rise_cyc = cyc;
        prev_rv = bus.resp_valid;
        @(posedge clk);
        cyc++;
        #1;
        bus.req_valid = bus.req_valid & ~hs;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_c[i*W +: W] = c;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic push_exp(input logic [W-1:0] d, input int id, input logic err);
        exp_t e;
        e.d   = d;
        e.id  = IDW'(id);
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        bit   got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            step();
            if (s_resp_hs) got = 1'b1;
        end
        check({tag, "_arrived"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({tag, "_d"},   64'(s_resp_d),   64'(e.d));
                check({tag, "_id"},  64'(s_resp_id),  64'(e.id));
                check({tag, "_err"}, 64'(s_resp_err), 64'(e.err));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 64'({bus.core_start, bus.core_reset, bus.resp_valid,
                                  bus.resp_err, bus.resp_id}), 64'b010000);
        check({tag, "_core_ops"}, 64'({bus.core_a, bus.core_b, bus.core_c}), 64'd0);
        check({tag, "_resp_d"}, 64'(bus.resp_d), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        check_reset_outputs("rst");
        reset = 1'b1;
        #1;
        check("core_reset_before_edge", 64'(bus.core_reset), 64'd1);
        step();
        check("core_reset_after_edge", 64'(bus.core_reset), 64'd0);
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_c      = '0;
        bus.resp_ready = 1'b1;

        // 1: single request on port 2, latency and pointer advance
        do_reset();
        n_start = 0;
        n_ready_cyc = 0;
        set_req(2, 16, 8, 4);
        push_exp(4, 2, 1'b0);
        wait_resp("t1");
        check("t1_ready_cycles", 64'(n_ready_cyc), 64'd1);
        check("t1_start_pulses", 64'(n_start), 64'd1);
        check("t1_start_latency", 64'(start_cyc - acc_cyc), 64'd1);
        check("t1_resp_latency", 64'(resp_rise_cyc - m_rise_cyc), 64'd1);
        set_req(1, 12, 18, 30);
        set_req(3, 16, 8, 4);
        push_exp(4, 3, 1'b0);
        push_exp(6, 1, 1'b0);
        wait_resp("t1_ptr_first");
        wait_resp("t1_ptr_second");

        // 2: all four requesting from reset, then wrap to 0
        for (int i = 0; i < NR; i++) set_req(i, 3571, 2711, 1543);
        do_reset();
        for (int i = 0; i < NR; i++) push_exp(1, i, 1'b0);
        for (int i = 0; i < NR; i++) wait_resp("t2_rr");
        set_req(0, 12, 18, 30);
        set_req(3, 16, 8, 4);
        push_exp(6, 0, 1'b0);
        push_exp(4, 3, 1'b0);
        wait_resp("t2_wrap_first");
        wait_resp("t2_wrap_second");

        // 3: stale valid (old D=4) lingers 3 cycles after start
        stale_cycles = 3;
        core_delay   = 6;
        set_req(0, 14, 21, 35);
        push_exp(7, 0, 1'b0);
        wait_resp("t3_stale");
        check("t3_resp_latency", 64'(resp_rise_cyc - m_rise_cyc), 64'd1);
        stale_cycles = 0;
        core_delay   = 5;

        // 4: hung core times out after TO wait cycles
        hang = 1'b1;
        n_core_rst = 0;
        set_req(2, 16, 8, 4);
        push_exp(0, 2, 1'b1);
        wait_resp("t4_timeout");
        check("t4_core_reset_cycles", 64'(n_core_rst), 64'd1);
        check("t4_abort_cycle", 64'(core_rst_cyc - start_cyc), 64'(TO + 1));
        check("t4_resp_cycle", 64'(resp_rise_cyc - start_cyc), 64'(TO + 2));
        hang = 1'b0;
        set_req(2, 16, 8, 4);
        push_exp(4, 2, 1'b0);
        wait_resp("t4_after");

        // 5: all-zero operands bypass the core; response held while not accepted
        n_start = 0;
        bus.resp_ready = 1'b0;
        set_req(1, 0, 0, 0);
        push_exp(0, 1, 1'b0);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                step();
                if (s_resp_valid) seen = 1'b1;
            end
            check("t5_resp_seen", 64'(seen), 64'd1);
        end
        set_req(3, 16, 8, 4);
        n_ready_cyc = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            check("t5_hold", 64'({s_resp_valid, s_resp_d, s_resp_id, s_resp_err}),
                  64'({1'b1, 16'h0, 2'd1, 1'b0}));
        end
        check("t5_no_start", 64'(n_start), 64'd0);
        check("t5_no_ready", 64'(n_ready_cyc), 64'd0);
        bus.resp_ready = 1'b1;
        push_exp(4, 3, 1'b0);
        wait_resp("t5_zero");
        wait_resp("t5_next");

        // 6: asynchronous reset in WAIT_HIGH, then re-request
        core_delay = 10;
        n_start = 0;
        set_req(2, 16, 8, 4);
        begin
            bit started = 1'b0;
            for (int n = 0; n < 20 && !started; n++) begin
                step();
                if (n_start != 0) started = 1'b1;
            end
            check("t6_started", 64'(started), 64'd1);
        end
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        exp_q.delete();
        core_delay = 5;
        step();
        step();
        set_req(2, 16, 8, 4);
        set_req(3, 12, 18, 30);
        push_exp(4, 2, 1'b0);
        push_exp(6, 3, 1'b0);
        reset = 1'b1;
        step();
        check("t6_core_reset_released", 64'(bus.core_reset), 64'd0);
        wait_resp("t6_regrant");
        wait_resp("t6_second");
        check("t6_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_share_arbiter.md
Name: gcd_share_arbiter

Overview:
Round-robin scheduler that shares one gcd_top core (three 16-bit operands A/B/C, start, result D, valid) among NUM_REQ requesters. It accepts one request at a time and drives the core's start/operands. It tracks completion with stale-valid rejection and a timeout, and returns the result on a single shared response channel tagged with the requester ID. It sits between the requester clients and the gcd_top core.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
ID_W, 2, width of resp_id; must be at least clog2(NUM_REQ)
W, 16, operand/result width; must match the core
TIMEOUT, 1024, maximum cycles spent in WAIT_LOW plus WAIT_HIGH before abort (must be at least 4)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  NUM_REQ  per-requester request; held with operands until accepted
req_a / req_b / req_c  in  NUM_REQ*W  flattened operands, requester i at [i*W +: W]
req_ready  out  NUM_REQ  one-hot accept strobe; transfer when req_valid[i] & req_ready[i]
core_start  out  1  one-cycle start pulse to core
core_a / core_b / core_c  out  W  operands to core, stable from START until the next accept
core_reset  out  1  active-high reset to core
core_d  in  W  core result
core_valid  in  1  core done flag; may stay high after completion
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_d  out  W  GCD result
resp_id  out  ID_W  index of requester served
resp_err  out  1  1 = core timed out, resp_d = 0

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr pointer=0, timeout counter=0.
- Output reset values: core_start=0, core_a/b/c=0, core_reset=1, resp_valid=0, resp_d=0, resp_id=0, resp_err=0.
- core_reset falls to 0 on the first clock edge after reset is released.
- A reset asserted mid-operation aborts immediately. The in-flight request is dropped, and its requester must re-request.
- States: IDLE, START, WAIT_LOW, WAIT_HIGH, RESP, ABORT.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr pointer upward with wrap.
  - req_ready = one-hot of that i (combinational from state, pointer and req_valid). req_ready is 0 in all other states.
  - On accept: latch operands into core_a/b/c, latch i into the ID register, set pointer = (i+1) mod NUM_REQ.
  - If all three operands are 0: go to RESP with resp_d=0, resp_err=0 (core bypassed, no core_start). Otherwise go to START.
- START: core_start=1 for exactly this cycle, clear timeout counter, then go to WAIT_LOW.
- WAIT_LOW: stale-valid guard. Ignore core_valid until it is sampled 0, then go to WAIT_HIGH.
- WAIT_HIGH: on the first sampled core_valid=1, register resp_d=core_d, resp_err=0, and go to RESP.
- Timeout: the counter increments each cycle in WAIT_LOW and WAIT_HIGH. On reaching TIMEOUT, go to ABORT; this takes priority over a same-cycle core_valid.
- ABORT (1 cycle): core_reset=1, resp_d=0, resp_err=1, then go to RESP.
- RESP:
  - resp_valid=1; resp_d/resp_id/resp_err held stable until resp_ready=1.
  - On handshake: resp_valid=0 next cycle, go to IDLE. No grant occurs in the handshake cycle.
- Minimum request-to-request spacing is one IDLE cycle after each response.
- Latency (accept at edge T): core_start high in the cycle after T. resp_valid rises one cycle after the qualifying core_valid edge.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 services.
- Requests that arrive while busy are not lost; they stay pending because the requester holds req_valid.
- Changing req operands while req_valid=1 and not accepted is a protocol violation. No checking is required.

Test Plan:
1. Reset, then req_valid[2]=1 with A=16, B=8, C=4; the core model returns D=4 five cycles after start → req_ready[2] one cycle, core_start single pulse, resp_valid with resp_d=4, resp_id=2, resp_err=0; next grant search starts at 3.
2. All four req_valid high from reset, A=3571, B=2711, C=1543 each, core D=1 → grants in order 0,1,2,3. Re-raise req0 and req3 together after port 3 is served → grant 0 first (pointer wrapped to 0).
3. Core model holds core_valid=1 from the previous op for 3 cycles after the new start, then drops, then raises with D=7 → previous stale D not returned; resp_d=7.
4. TIMEOUT=16, core_valid never rises → resp_err=1, resp_d=0 after 16 wait cycles, core_reset high exactly one cycle; a following request (16,8,4) completes normally with D=4.
5. Operands (0,0,0) on port 1 with resp_ready held low for 10 cycles → no core_start, resp_valid steady with resp_d=0, resp_id=1 for all 10 cycles; no req_ready during that time; release → IDLE.
6. Drive reset=0 mid-WAIT_HIGH for 2 cycles → all outputs take reset values immediately (asynchronously), core_reset=1, pointer=0; after release the pending request is re-granted and completes correctly.
